// File: rtl/mem_lsu.sv
// mem_lsu: load/store unit between an RV32I-style core request channel and a
// single-port word memory with a registered read path.
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   req_valid/req_ready   request handshake (ready only while idle)
//   req_we                1 = store, 0 = load
//   req_funct3            RV32I size/sign code
//   req_addr              byte address
//   req_wdata             right-aligned store data
//   resp_valid/resp_ready response handshake
//   resp_rdata            extended load result (0 for stores and errors)
//   resp_err              misaligned access or illegal funct3
//   mem_addr              word address to the memory
//   mem_be                byte enables
//   mem_wdata             lane-replicated write data
//   mem_we                write strobe
//   mem_rdata             read data, valid the cycle after the address
module mem_lsu #(
  parameter int ADDRESS_WIDTH = 10
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_we,
  input  logic [2:0]               req_funct3,
  input  logic [31:0]              req_addr,
  input  logic [31:0]              req_wdata,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [31:0]              resp_rdata,
  output logic                     resp_err,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  output logic [3:0]               mem_be,
  output logic [31:0]              mem_wdata,
  output logic                     mem_we,
  input  logic [31:0]              mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, LATCH, RESP} state_t;

  state_t      state, state_nx;
  logic        we_q;
  logic [2:0]  f3_q;
  logic [31:0] addr_q;

  logic        accept;
  logic        illegal;
  logic        misaligned;
  logic        req_bad;
  logic [31:0] wdata_repl;
  logic [31:0] rd_shift;
  logic [31:0] load_data;

  assign accept = req_valid && req_ready;

  // Request classification, evaluated on the raw request so the error path
  // can skip the memory states entirely.
  always_comb begin
    illegal = 1'b0;
    case (req_funct3)
      3'b011, 3'b110, 3'b111: illegal = 1'b1;
      default:                illegal = 1'b0;
    endcase
    if (req_we && req_funct3[2]) illegal = 1'b1;
    misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                 ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    req_bad = illegal || misaligned;
  end

  // Store data is replicated across lanes at accept time and held in
  // mem_wdata itself, which doubles as the registered copy of wdata.
  always_comb begin
    case (req_funct3[1:0])
      2'b00:   wdata_repl = {4{req_wdata[7:0]}};
      2'b01:   wdata_repl = {2{req_wdata[15:0]}};
      default: wdata_repl = req_wdata;
    endcase
  end

  // Load extraction from the registered read data.
  always_comb begin
    rd_shift  = mem_rdata >> {addr_q[1:0], 3'b000};
    load_data = '0;
    case (f3_q)
      3'b000:  load_data = {{24{rd_shift[7]}}, rd_shift[7:0]};
      3'b100:  load_data = {24'b0, rd_shift[7:0]};
      3'b001:  load_data = addr_q[1] ? {{16{mem_rdata[31]}}, mem_rdata[31:16]}
                                     : {{16{mem_rdata[15]}}, mem_rdata[15:0]};
      3'b101:  load_data = addr_q[1] ? {16'b0, mem_rdata[31:16]}
                                     : {16'b0, mem_rdata[15:0]};
      3'b010:  load_data = mem_rdata;
      default: load_data = '0;
    endcase
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = req_bad ? RESP : ACCESS;
      ACCESS:  state_nx = LATCH;
      LATCH:   state_nx = RESP;
      RESP:    if (resp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    req_ready  = (state == IDLE);
    resp_valid = (state == RESP);
    mem_we     = (state == ACCESS) && we_q && !reset;
    mem_be     = 4'b0000;
    if ((state == ACCESS) && we_q) begin
      case (f3_q[1:0])
        2'b00:   mem_be = 4'b0001 << addr_q[1:0];
        2'b01:   mem_be = addr_q[1] ? 4'b1100 : 4'b0011;
        default: mem_be = 4'b1111;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      we_q       <= 1'b0;
      f3_q       <= '0;
      addr_q     <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        we_q       <= req_we;
        f3_q       <= req_funct3;
        addr_q     <= req_addr;
        resp_err   <= req_bad;
        resp_rdata <= '0;
        // mem_addr is registered here so it is already valid in ACCESS;
        // error requests leave the memory port untouched.
        if (!req_bad) begin
          mem_addr <= req_addr[ADDRESS_WIDTH+1:2];
          if (req_we) mem_wdata <= wdata_repl;
        end
      end
      if (state == LATCH) resp_rdata <= we_q ? 32'b0 : load_data;
    end
  end

endmodule

// File: tb/tb_mem_lsu.sv
module tb_mem_lsu;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [9:0]  mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic [31:0] mem_rdata;

  int checks = 0;
  int errors = 0;
  logic [9:0] last_maddr = '0;

  logic [31:0] mem [0:1023];

  mem_lsu #(.ADDRESS_WIDTH(10)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Byte-enabled memory with registered read (old data on same-cycle write).
  always @(posedge clk) begin
    if (mem_we) begin
      for (int unsigned b = 0; b < 4; b++)
        if (mem_be[b]) mem[mem_addr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
    end
    mem_rdata <= mem[mem_addr];
  end

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
    logic [3:0]  be;
    logic [31:0] mwd;
    logic [9:0]  maddr;
  } vec_t;

  localparam int N = 24;
  vec_t tv [0:N-1];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drives one request with resp_ready high and checks each cycle of it.
  task automatic do_req(input int id, input vec_t t);
    @(negedge clk);
    chk($sformatf("v%0d req_ready", id), 32'(req_ready), 32'd1);
    req_valid  = 1'b1;
    req_we     = t.we;
    req_funct3 = t.f3;
    req_addr   = t.addr;
    req_wdata  = t.wdata;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    if (t.err) begin
      chk($sformatf("v%0d err resp_valid", id), 32'(resp_valid), 32'd1);
      chk($sformatf("v%0d err resp_err", id), 32'(resp_err), 32'd1);
      chk($sformatf("v%0d err rdata", id), resp_rdata, 32'd0);
      chk($sformatf("v%0d err mem_we", id), 32'(mem_we), 32'd0);
      chk($sformatf("v%0d err mem_addr", id), 32'(mem_addr), 32'(last_maddr));
      @(posedge clk); #1;
      chk($sformatf("v%0d err done", id), 32'(resp_valid), 32'd0);
    end else begin
      chk($sformatf("v%0d access resp_valid", id), 32'(resp_valid), 32'd0);
      chk($sformatf("v%0d mem_we", id), 32'(mem_we), 32'(t.we));
      chk($sformatf("v%0d mem_be", id), 32'(mem_be), 32'(t.be));
      chk($sformatf("v%0d mem_addr", id), 32'(mem_addr), 32'(t.maddr));
      if (t.we) chk($sformatf("v%0d mem_wdata", id), mem_wdata, t.mwd);
      last_maddr = t.maddr;
      @(posedge clk); #1;
      chk($sformatf("v%0d latch resp_valid", id), 32'(resp_valid), 32'd0);
      chk($sformatf("v%0d latch mem_we", id), 32'(mem_we), 32'd0);
      chk($sformatf("v%0d latch mem_addr", id), 32'(mem_addr), 32'(t.maddr));
      @(posedge clk); #1;
      chk($sformatf("v%0d resp_valid", id), 32'(resp_valid), 32'd1);
      chk($sformatf("v%0d rdata", id), resp_rdata, t.rdata);
      chk($sformatf("v%0d resp_err", id), 32'(resp_err), 32'd0);
      @(posedge clk); #1;
      chk($sformatf("v%0d done", id), 32'(resp_valid), 32'd0);
    end
  endtask

  initial begin
    vec_t t;
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    //            we    f3      addr          wdata         rdata         err   be       mwd           maddr
    tv[0]  = '{1'b1, 3'b010, 32'h10,   32'hDEADBEEF, 32'h0,        1'b0, 4'b1111, 32'hDEADBEEF, 10'd4};
    tv[1]  = '{1'b0, 3'b000, 32'h13,   32'h0,        32'hFFFFFFDE, 1'b0, 4'b0000, 32'h0,        10'd4};
    tv[2]  = '{1'b0, 3'b100, 32'h13,   32'h0,        32'h000000DE, 1'b0, 4'b0000, 32'h0,        10'd4};
    tv[3]  = '{1'b0, 3'b001, 32'h12,   32'h0,        32'hFFFFDEAD, 1'b0, 4'b0000, 32'h0,        10'd4};
    tv[4]  = '{1'b0, 3'b101, 32'h10,   32'h0,        32'h0000BEEF, 1'b0, 4'b0000, 32'h0,        10'd4};
    tv[5]  = '{1'b1, 3'b000, 32'h11,   32'hAAAAAA55, 32'h0,        1'b0, 4'b0010, 32'h55555555, 10'd4};
    tv[6]  = '{1'b0, 3'b010, 32'h10,   32'h0,        32'hDEAD55EF, 1'b0, 4'b0000, 32'h0,        10'd4};
    tv[7]  = '{1'b0, 3'b010, 32'h12,   32'h0,        32'h0,        1'b1, 4'b0000, 32'h0,        10'd0};
    tv[8]  = '{1'b0, 3'b011, 32'h10,   32'h0,        32'h0,        1'b1, 4'b0000, 32'h0,        10'd0};
    tv[9]  = '{1'b1, 3'b001, 32'h16,   32'hFFFF8001, 32'h0,        1'b0, 4'b1100, 32'h80018001, 10'd5};
    tv[10] = '{1'b0, 3'b001, 32'h16,   32'h0,        32'hFFFF8001, 1'b0, 4'b0000, 32'h0,        10'd5};
    tv[11] = '{1'b0, 3'b101, 32'h16,   32'h0,        32'h00008001, 1'b0, 4'b0000, 32'h0,        10'd5};
    tv[12] = '{1'b1, 3'b100, 32'h10,   32'h1,        32'h0,        1'b1, 4'b0000, 32'h0,        10'd0};
    tv[13] = '{1'b0, 3'b001, 32'h11,   32'h0,        32'h0,        1'b1, 4'b0000, 32'h0,        10'd0};
    tv[14] = '{1'b1, 3'b001, 32'h13,   32'h1234,     32'h0,        1'b1, 4'b0000, 32'h0,        10'd0};
    tv[15] = '{1'b1, 3'b010, 32'h1014, 32'h0BADF00D, 32'h0,        1'b0, 4'b1111, 32'h0BADF00D, 10'd5};
    tv[16] = '{1'b0, 3'b010, 32'h14,   32'h0,        32'h0BADF00D, 1'b0, 4'b0000, 32'h0,        10'd5};
    tv[17] = '{1'b0, 3'b000, 32'h15,   32'h0,        32'hFFFFFFF0, 1'b0, 4'b0000, 32'h0,        10'd5};
    tv[18] = '{1'b0, 3'b100, 32'h17,   32'h0,        32'h0000000B, 1'b0, 4'b0000, 32'h0,        10'd5};
    tv[19] = '{1'b0, 3'b000, 32'h16,   32'h0,        32'hFFFFFFAD, 1'b0, 4'b0000, 32'h0,        10'd5};
    tv[20] = '{1'b1, 3'b010, 32'h16,   32'h5,        32'h0,        1'b1, 4'b0000, 32'h0,        10'd0};
    tv[21] = '{1'b0, 3'b110, 32'h0,    32'h0,        32'h0,        1'b1, 4'b0000, 32'h0,        10'd0};
    tv[22] = '{1'b1, 3'b000, 32'h13,   32'h0000007F, 32'h0,        1'b0, 4'b1000, 32'h7F7F7F7F, 10'd4};
    tv[23] = '{1'b0, 3'b010, 32'h10,   32'h0,        32'h7FAD55EF, 1'b0, 4'b0000, 32'h0,        10'd4};

    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0;
    req_addr = '0; req_wdata = '0; resp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset mem_we", 32'(mem_we), 32'd0);
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    chk("reset req_ready", 32'(req_ready), 32'd1);
    chk("reset resp_valid", 32'(resp_valid), 32'd0);
    chk("reset resp_rdata", resp_rdata, 32'd0);
    chk("reset resp_err", 32'(resp_err), 32'd0);
    chk("reset mem_addr", 32'(mem_addr), 32'd0);
    chk("reset mem_wdata", mem_wdata, 32'd0);
    chk("reset mem_be", 32'(mem_be), 32'd0);

    for (int i = 0; i < N; i++) do_req(i, tv[i]);
    chk("mem word4", mem[4], 32'h7FAD55EF);
    chk("mem word5", mem[5], 32'h0BADF00D);

    // Backpressure: response held for 5 cycles, stray request ignored.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h10;
    resp_ready = 1'b0;
    @(posedge clk); #1; req_valid = 1'b0;
    repeat (2) @(posedge clk);
    for (int c = 0; c < 5; c++) begin
      #1;
      chk($sformatf("bp%0d resp_valid", c), 32'(resp_valid), 32'd1);
      chk($sformatf("bp%0d rdata", c), resp_rdata, 32'h7FAD55EF);
      chk($sformatf("bp%0d req_ready", c), 32'(req_ready), 32'd0);
      chk($sformatf("bp%0d mem_we", c), 32'(mem_we), 32'd0);
      if (c == 2) begin
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
        req_addr = 32'h20; req_wdata = 32'hCAFEF00D;
      end else begin
        req_valid = 1'b0;
      end
      @(posedge clk);
    end
    #1; req_valid = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp release resp_valid", 32'(resp_valid), 32'd0);
    chk("bp release req_ready", 32'(req_ready), 32'd1);
    chk("bp stray write", mem[8], 32'd0);

    // Reset during the ACCESS cycle of a store must suppress the write.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
    req_addr = 32'h20; req_wdata = 32'h12345678;
    @(posedge clk); #1; req_valid = 1'b0;
    chk("rst access mem_we pre", 32'(mem_we), 32'd1);
    chk("rst access mem_addr", 32'(mem_addr), 32'd8);
    reset = 1'b1;
    #1;
    chk("rst access mem_we gated", 32'(mem_we), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    chk("rst after req_ready", 32'(req_ready), 32'd1);
    chk("rst after resp_valid", 32'(resp_valid), 32'd0);
    chk("rst after mem_addr", 32'(mem_addr), 32'd0);
    chk("rst word8", mem[8], 32'd0);
    last_maddr = '0;

    t = '{1'b0, 3'b010, 32'h20, 32'h0, 32'h0, 1'b0, 4'b0000, 32'h0, 10'd8};
    do_req(100, t);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
